scanline_fetcher: RTL
=====================

Name: scanline_fetcher

Overview:
- Parametrised multi-layer scanline DMA engine for the video pipeline, in the system `clk` domain.
- On each line-start strobe it fetches one scanline per enabled layer from memory via AXI4 read bursts.
- Fetched words are written into per-layer ping-pong line buffers; the pixel-clock side reads the opposite bank.
- Generalises the single-text/single-graphic fetch to N layers with programmable base, stride, line length and burst size, plus underrun reporting.

Parameters:
- NUM_LAYERS, 2, number of independent layers (1..8).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; bytes per beat = DATA_W/8.
- BURST_LEN, 64, maximum beats per burst (1..256).
- WORDS_W, 11, width of per-layer words-per-line count.
- LINE_W, 10, width of line index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- line_start  in  1  single-cycle pulse, already synchronised to clk
- line_y  in  LINE_W  line to fetch; valid with line_start
- cfg_enable  in  NUM_LAYERS  per-layer enable
- cfg_base  in  NUM_LAYERS*ADDR_W  per-layer base byte address
- cfg_stride  in  NUM_LAYERS*ADDR_W  per-layer bytes per line
- cfg_words  in  NUM_LAYERS*WORDS_W  per-layer beats per line
- axi_ar_valid  out  1  read address valid
- axi_ar_ready  in  1  read address ready
- axi_ar_addr  out  ADDR_W  burst start address
- axi_ar_len  out  8  beats-1
- axi_ar_burst  out  2  constant 2'b01 (INCR)
- axi_r_valid  in  1  read data valid
- axi_r_ready  out  1  constant 1
- axi_r_data  in  DATA_W  read data
- axi_r_last  in  1  last beat of burst
- buf_we  out  1  line-buffer write strobe
- buf_layer  out  clog2(NUM_LAYERS) max 1  target layer
- buf_addr  out  WORDS_W+1  {bank, word index}; bank = line_y[0]
- buf_wdata  out  DATA_W  word to write
- busy  out  1  fetch in progress
- line_done  out  1  one-cycle pulse when all layers of a line are complete
- underrun  out  NUM_LAYERS  sticky per-layer bit; cleared only by reset

Behaviour:
- Reset values:
  - axi_ar_valid=0, buf_we=0, busy=0, line_done=0, underrun=0.
  - axi_ar_addr, axi_ar_len and buf_addr reset to 0.
  - State resets to IDLE.
- Configuration snapshot: cfg_* and line_y are captured on line_start; changes during a fetch have no effect until the next line.
- FSM states:
  - IDLE: on line_start, go to CALC with layer=0, busy=1.
  - CALC: one cycle; line_off = line_y*stride of the current layer, truncated to ADDR_W; burst index=0; remaining=cfg_words.
    - If the layer is disabled or cfg_words==0, go to NEXT.
    - Otherwise go to ADDR.
  - ADDR: axi_ar_valid=1.
    - addr = base + line_off + burst_idx*BURST_LEN*(DATA_W/8), modulo 2^ADDR_W.
    - len = min(remaining, BURST_LEN)-1.
    - addr and len stay stable until axi_ar_ready; on handshake, deassert valid next cycle and go to DATA.
  - DATA: each axi_r_valid beat causes, one cycle later, buf_we=1 with buf_wdata=beat, buf_layer=layer and buf_addr={bank, word_idx}; word_idx then increments.
    - On the beat with axi_r_last: remaining -= len+1. If remaining>0 go to ADDR, else go to NEXT.
  - NEXT: layer+1. If layer==NUM_LAYERS-1, go to IDLE, pulse line_done, busy=0. Otherwise go to CALC.
- Outstanding requests: at most one burst is outstanding. axi_r_valid outside DATA is ignored.
- word_idx restarts at 0 per layer. Writes past 2^WORDS_W words wrap within the bank.
- Latency: line_start at cycle 0 gives axi_ar_valid at cycle 2 when layer 0 is enabled and nonzero.
- line_start while busy:
  - Set underrun bit of the layer being fetched.
  - Latch the new line_y and snapshot.
  - ADDR or CALC: abort immediately if the address has not yet handshaken; ADDR deasserts axi_ar_valid next cycle.
  - DATA: finish the current burst through r_last, writing its beats normally.
  - Drop the remaining layers and bursts of the old line (no line_done), then restart at CALC layer 0 for the new line.
  - A second line_start during the drain only updates the latched line.
- Simultaneous r_last and line_start: treated as line_start while busy with the burst complete, so restart happens next cycle.
- Reset mid-burst: all state clears immediately. Remaining R beats from the interconnect are accepted (r_ready=1) and discarded.

Test Plan:
- Layer0 only: base=0x1000_0000, stride=0x1000, words=100, BURST_LEN=64, line_y=5 -> two ARs.
  - AR1: addr 0x1000_5000, len 63. AR2: addr 0x1000_5100, len 35.
  - 100 buf_we with buf_addr 0x400..0x463 (bank 1).
  - line_done at end.
- Two layers, layer0 disabled, layer1 words=64, line_y=2 -> single AR for layer1 with len 63.
  - buf_layer=1 throughout, bank 0.
  - line_done once.
- axi_ar_ready held low 10 cycles -> axi_ar_valid, addr and len stable for all 10 cycles; exactly one handshake.
- line_start arrives during the 20th beat of the 64-beat first burst of layer0 -> remaining 44 beats are still written.
  - underrun=2'b01.
  - Next AR is for the new line's layer0.
  - No line_done for the old line.
- Address wrap: base=0xFFFF_FF00, stride=0, words=128 -> AR1 addr 0xFFFF_FF00, AR2 addr 0x0000_0000.
- Reset asserted in DATA after 3 beats -> next cycle axi_ar_valid=0, busy=0, buf_we=0, underrun=0.
  - Subsequent stray R beats produce no buf_we.

Source files
------------

// File: rtl/scanline_fetcher.sv
// Multi-layer scanline DMA engine: on each line start, fetches one scanline per
// enabled layer with AXI4 INCR read bursts and writes the beats into per-layer
// ping-pong line buffers (bank chosen by the line's parity).
module scanline_fetcher #(
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned WORDS_W    = 11,
    parameter int unsigned LINE_W     = 10,
    localparam int unsigned LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          line_start,
    input  logic [LINE_W-1:0]             line_y,
    input  logic [NUM_LAYERS-1:0]         cfg_enable,
    input  logic [NUM_LAYERS*ADDR_W-1:0]  cfg_base,
    input  logic [NUM_LAYERS*ADDR_W-1:0]  cfg_stride,
    input  logic [NUM_LAYERS*WORDS_W-1:0] cfg_words,
    output logic                          axi_ar_valid,
    input  logic                          axi_ar_ready,
    output logic [ADDR_W-1:0]             axi_ar_addr,
    output logic [7:0]                    axi_ar_len,
    output logic [1:0]                    axi_ar_burst,
    input  logic                          axi_r_valid,
    output logic                          axi_r_ready,
    input  logic [DATA_W-1:0]             axi_r_data,
    input  logic                          axi_r_last,
    output logic                          buf_we,
    output logic [LAYER_W-1:0]            buf_layer,
    output logic [WORDS_W:0]              buf_addr,
    output logic [DATA_W-1:0]             buf_wdata,
    output logic                          busy,
    output logic                          line_done,
    output logic [NUM_LAYERS-1:0]         underrun
);

    localparam int unsigned BURST_BYTES = BURST_LEN * (DATA_W / 8);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_NEXT = 3'd4;

    logic [2:0]                    state_q, state_d;
    logic [LAYER_W-1:0]            layer_q, layer_d;
    logic [LINE_W-1:0]             line_y_q, line_y_d;
    logic [NUM_LAYERS-1:0]         en_q, en_d;
    logic [NUM_LAYERS*ADDR_W-1:0]  base_q, base_d;
    logic [NUM_LAYERS*ADDR_W-1:0]  stride_q, stride_d;
    logic [NUM_LAYERS*WORDS_W-1:0] words_q, words_d;
    logic [WORDS_W-1:0]            rem_q, rem_d;
    logic [WORDS_W-1:0]            word_idx_q, word_idx_d;
    logic                          bank_q, bank_d;
    logic                          pend_q, pend_d;
    logic                          ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0]             ar_addr_q, ar_addr_d;
    logic [7:0]                    ar_len_q, ar_len_d;
    logic                          buf_we_q, buf_we_d;
    logic [LAYER_W-1:0]            buf_layer_q, buf_layer_d;
    logic [WORDS_W:0]              buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]             buf_wdata_q, buf_wdata_d;
    logic                          busy_q, busy_d;
    logic                          line_done_q, line_done_d;
    logic [NUM_LAYERS-1:0]         underrun_q, underrun_d;

    logic [ADDR_W-1:0]             cur_base;
    logic [ADDR_W-1:0]             cur_stride;
    logic [WORDS_W-1:0]            cur_words;
    logic                          cur_en;
    logic [ADDR_W-1:0]             line_off;
    logic [WORDS_W-1:0]            rem_after;

    // Beats-1 of the next burst: min(remaining, BURST_LEN) - 1 (remaining is nonzero)
    function automatic logic [7:0] burst_len_m1(input logic [WORDS_W-1:0] rem);
        if (32'(rem) >= BURST_LEN) begin
            return 8'(BURST_LEN - 1);
        end
        return 8'(32'(rem) - 32'd1);
    endfunction

    // Per-layer view of the configuration snapshot
    assign cur_base   = base_q[32'(layer_q)*ADDR_W +: ADDR_W];
    assign cur_stride = stride_q[32'(layer_q)*ADDR_W +: ADDR_W];
    assign cur_words  = words_q[32'(layer_q)*WORDS_W +: WORDS_W];
    assign cur_en     = en_q[layer_q];
    assign line_off   = ADDR_W'(line_y_q) * cur_stride;
    assign rem_after  = WORDS_W'(32'(rem_q) - 32'(ar_len_q) - 32'd1);

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        line_y_d    = line_y_q;
        en_d        = en_q;
        base_d      = base_q;
        stride_d    = stride_q;
        words_d     = words_q;
        rem_d       = rem_q;
        word_idx_d  = word_idx_q;
        bank_d      = bank_q;
        pend_d      = pend_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        buf_we_d    = 1'b0;
        buf_layer_d = buf_layer_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        line_done_d = 1'b0;
        underrun_d  = underrun_q;

        // Every line start refreshes the snapshot; one arriving mid-fetch is an underrun
        if (line_start) begin
            line_y_d = line_y;
            en_d     = cfg_enable;
            base_d   = cfg_base;
            stride_d = cfg_stride;
            words_d  = cfg_words;
            if (state_q != ST_IDLE) begin
                underrun_d[layer_q] = 1'b1;
                pend_d              = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (line_start) begin
                    state_d = ST_CALC;
                    layer_d = '0;
                end
            end
            ST_CALC: begin
                if (line_start) begin
                    layer_d = '0;
                    pend_d  = 1'b0;
                end else if (!cur_en || cur_words == '0) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d    = ST_ADDR;
                    rem_d      = cur_words;
                    word_idx_d = '0;
                    bank_d     = line_y_q[0];
                    ar_valid_d = 1'b1;
                    ar_addr_d  = cur_base + line_off;
                    ar_len_d   = burst_len_m1(cur_words);
                end
            end
            ST_ADDR: begin
                if (ar_valid_q && axi_ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = ST_DATA;
                end else if (line_start) begin
                    ar_valid_d = 1'b0;
                    state_d    = ST_CALC;
                    layer_d    = '0;
                    pend_d     = 1'b0;
                end
            end
            ST_DATA: begin
                if (axi_r_valid) begin
                    buf_we_d    = 1'b1;
                    buf_wdata_d = axi_r_data;
                    buf_layer_d = layer_q;
                    buf_addr_d  = {bank_q, word_idx_q};
                    word_idx_d  = word_idx_q + WORDS_W'(1);
                    if (axi_r_last) begin
                        rem_d = rem_after;
                        if (pend_q || line_start) begin
                            state_d = ST_CALC;
                            layer_d = '0;
                            pend_d  = 1'b0;
                        end else if (rem_after != '0) begin
                            state_d    = ST_ADDR;
                            ar_valid_d = 1'b1;
                            ar_addr_d  = ar_addr_q + ADDR_W'(BURST_BYTES);
                            ar_len_d   = burst_len_m1(rem_after);
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end
                end
            end
            ST_NEXT: begin
                if (line_start) begin
                    state_d = ST_CALC;
                    layer_d = '0;
                    pend_d  = 1'b0;
                end else if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
                    state_d     = ST_IDLE;
                    line_done_d = 1'b1;
                end else begin
                    state_d = ST_CALC;
                    layer_d = layer_q + LAYER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            layer_q     <= '0;
            line_y_q    <= '0;
            en_q        <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            words_q     <= '0;
            rem_q       <= '0;
            word_idx_q  <= '0;
            bank_q      <= 1'b0;
            pend_q      <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            buf_we_q    <= 1'b0;
            buf_layer_q <= '0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            line_y_q    <= line_y_d;
            en_q        <= en_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            words_q     <= words_d;
            rem_q       <= rem_d;
            word_idx_q  <= word_idx_d;
            bank_q      <= bank_d;
            pend_q      <= pend_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            buf_we_q    <= buf_we_d;
            buf_layer_q <= buf_layer_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign axi_ar_valid = ar_valid_q;
    assign axi_ar_addr  = ar_addr_q;
    assign axi_ar_len   = ar_len_q;
    assign axi_ar_burst = 2'b01;
    assign axi_r_ready  = 1'b1;
    assign buf_we       = buf_we_q;
    assign buf_layer    = buf_layer_q;
    assign buf_addr     = buf_addr_q;
    assign buf_wdata    = buf_wdata_q;
    assign busy         = busy_q;
    assign line_done    = line_done_q;
    assign underrun     = underrun_q;

endmodule
